// File: rtl/game_defs_pkg.sv
// Tile-grid definitions shared by the game block and the paddle controller.
// The move-request decode is kept here so both blocks agree on button semantics.
package game_defs;

    localparam int GAME_WIDTH  = 40;
    localparam int GAME_HEIGHT = 30;
    localparam int TILE_W      = 6;
    localparam int PADDLE_Y_W  = 5;

    typedef logic [TILE_W-1:0] tile_t;

    typedef enum logic [1:0] {
        MOVE_HOLD = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2
    } move_e;

    // Both buttons together cancel out, the same as no button.
    function automatic move_e move_request(input logic up, input logic dn);
        move_e req;
        req = MOVE_HOLD;
        if (up && !dn) begin
            req = MOVE_UP;
        end else if (dn && !up) begin
            req = MOVE_DOWN;
        end
        return req;
    endfunction

endpackage

// File: rtl/debounce_switch.sv
// Two-flop synchronizer followed by a stable-state debouncer for one raw switch.
// The state toggles only after DEBOUNCE_LIMIT consecutive cycles of disagreement.
module debounce_switch #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic state
);

    localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            state   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= sw;
            sync_p1 <= sync_p0;
            // Any return to the stable level restarts the qualification window.
            if (sync_p1 == state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                state <= sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Player paddle controller: debounced buttons step the paddle one tile during
// vertical blanking, and a registered draw flag marks the paddle's tiles.
module paddle_ctrl
    import game_defs::*;
#(
    parameter int GAME_WIDTH      = game_defs::GAME_WIDTH,
    parameter int GAME_HEIGHT     = game_defs::GAME_HEIGHT,
    parameter int PADDLE_HEIGHT   = 6,
    parameter int PADDLE_COL      = 0,
    parameter int DEBOUNCE_LIMIT  = 250000,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Sw_Up,
    input  logic                  i_Sw_Dn,
    input  tile_t                 i_row,
    input  tile_t                 i_col,
    output logic [PADDLE_Y_W-1:0] o_paddle_y,
    output logic                  o_draw,
    output logic                  o_moving
);

    localparam int Y_MAX  = GAME_HEIGHT - PADDLE_HEIGHT;
    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [PADDLE_Y_W-1:0] Y_RESET   = PADDLE_Y_W'(Y_MAX / 2);
    localparam logic [PADDLE_Y_W-1:0] Y_LIMIT   = PADDLE_Y_W'(Y_MAX);
    localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

    localparam tile_t ROW_BLANK  = tile_t'(GAME_HEIGHT);
    localparam tile_t ROW_LAST   = tile_t'(GAME_HEIGHT - 1);
    localparam tile_t COL_PADDLE = tile_t'(PADDLE_COL);
    localparam tile_t COL_END    = tile_t'(GAME_WIDTH);
    localparam tile_t PADDLE_LEN = tile_t'(PADDLE_HEIGHT);

    logic              up_db;
    logic              dn_db;
    tile_t             row_p0;
    logic [STEP_W-1:0] step_cnt;
    logic              tick;
    logic              step;
    move_e             req;
    tile_t             y_ext;
    logic              row_hit;
    logic              col_hit;

    debounce_switch #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_db_up (
        .clk  (i_Clk),
        .rst  (i_Rst),
        .sw   (i_Sw_Up),
        .state(up_db)
    );

    debounce_switch #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_db_dn (
        .clk  (i_Clk),
        .rst  (i_Rst),
        .sw   (i_Sw_Dn),
        .state(dn_db)
    );

    always_comb begin
        // Entering the first invisible row happens exactly once per frame.
        tick    = (i_row == ROW_BLANK) && (row_p0 == ROW_LAST);
        step    = tick && (step_cnt == STEP_LAST);
        req     = move_request(up_db, dn_db);
        y_ext   = {1'b0, o_paddle_y};
        row_hit = (i_row >= y_ext) && (i_row < y_ext + PADDLE_LEN) && (i_row < ROW_BLANK);
        col_hit = (i_col == COL_PADDLE) && (i_col < COL_END);
    end

    // Stage p0: frame tick and step divider
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            row_p0   <= '0;
            step_cnt <= '0;
        end else begin
            row_p0 <= i_row;
            if (tick) begin
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
            end
        end
    end

    // Stage p1: paddle position and move pulse
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_paddle_y <= Y_RESET;
            o_moving   <= 1'b0;
        end else begin
            o_moving <= 1'b0;
            if (step) begin
                case (req)
                    MOVE_UP: begin
                        if (o_paddle_y != '0) begin
                            o_paddle_y <= o_paddle_y - 1'b1;
                            o_moving   <= 1'b1;
                        end
                    end
                    MOVE_DOWN: begin
                        if (o_paddle_y < Y_LIMIT) begin
                            o_paddle_y <= o_paddle_y + 1'b1;
                            o_moving   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Stage p1: draw flag, one cycle behind the tile coordinates
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_draw <= 1'b0;
        end else begin
            o_draw <= col_hit && row_hit;
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl with a reduced-width tile scan; draw flags and moves
// are predicted into queues and compared as the DUT produces them.
module tb_paddle_ctrl;

    localparam int H_TILES   = 8;
    localparam int V_TILES   = 32;
    localparam int FRAME_CYC = H_TILES * V_TILES;
    localparam logic [5:0] H_LAST = 6'(H_TILES - 1);
    localparam logic [5:0] V_LAST = 6'(V_TILES - 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_up;
    logic       sw_dn;
    logic [5:0] row;
    logic [5:0] col;
    logic [4:0] paddle_y;
    logic       draw;
    logic       moving;

    int checks   = 0;
    int failures = 0;
    int exp_y    = 12;
    bit chk_req  = 1'b0;
    bit chk_on   = 1'b0;
    bit draw_q[$];
    int move_q[$];

    paddle_ctrl #(
        .PADDLE_HEIGHT  (6),
        .PADDLE_COL     (0),
        .DEBOUNCE_LIMIT (4),
        .FRAMES_PER_STEP(2)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_Sw_Up   (sw_up),
        .i_Sw_Dn   (sw_dn),
        .i_row     (row),
        .i_col     (col),
        .o_paddle_y(paddle_y),
        .o_draw    (draw),
        .o_moving  (moving)
    );

    always #5 clk = ~clk;

    function automatic bit expected_draw(input logic [5:0] r, input logic [5:0] c, input int y);
        int ri;
        ri = int'(r);
        return (c == 6'd0) && (ri >= y) && (ri < y + 6) && (ri < 30);
    endfunction

    // Tile scan: one tile per clock, updated on the falling edge.
    initial begin
        row = '0;
        col = '0;
        forever begin
            @(negedge clk);
            if (col == H_LAST) begin
                col = '0;
                row = (row == V_LAST) ? 6'd0 : row + 6'd1;
            end else begin
                col = col + 6'd1;
            end
            if (row == 6'd0 && col == 6'd0) begin
                chk_on  = chk_req;
                chk_req = 1'b0;
            end
            if (chk_on) draw_q.push_back(expected_draw(row, col, exp_y));
        end
    end

    // Output monitor: pops predicted draw flags and moves.
    initial begin
        bit exp_d;
        int ey;
        forever begin
            @(posedge clk);
            #1;
            if (draw_q.size() > 0) begin
                exp_d = draw_q.pop_front();
                checks++;
                if (draw !== exp_d) begin
                    failures++;
                    $display("FAIL draw row_now=%0d got=%0b want=%0b", row, draw, exp_d);
                end
            end
            if (moving === 1'b1) begin
                checks++;
                if (move_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_move y=%0d row=%0d want=no pulse", paddle_y, row);
                end else begin
                    ey = move_q.pop_front();
                    if (paddle_y !== 5'(ey) || row !== 6'd30) begin
                        failures++;
                        $display("FAIL move y=%0d row=%0d want y=%0d row=30", paddle_y, row, ey);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_tile(input logic [5:0] r, input logic [5:0] c);
        for (int i = 0; i < FRAME_CYC + 8; i++) begin
            @(posedge clk);
            #1;
            if (row == r && col == c) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_tile timeout got row=%0d col=%0d want row=%0d col=%0d", row, col, r, c);
    endtask

    task automatic run_draw_frame();
        chk_req = 1'b1;
        wait_tile(6'd0, 6'd0);
        wait_tile(6'd0, 6'd0);
        @(posedge clk);
        #1;
        checks++;
        if (draw_q.size() != 0) begin
            failures++;
            $display("FAIL draw_drain left=%0d want=0", draw_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (paddle_y !== 5'd12) begin
            failures++;
            $display("FAIL reset_y got=%0d want=12", paddle_y);
        end
        checks++;
        if (draw !== 1'b0) begin
            failures++;
            $display("FAIL reset_draw got=%0b want=0", draw);
        end
        checks++;
        if (moving !== 1'b0) begin
            failures++;
            $display("FAIL reset_moving got=%0b want=0", moving);
        end
        @(negedge clk);
        rst   = 1'b0;
        exp_y = 12;
        run_draw_frame();
        checks++;
        if (paddle_y !== 5'd12) begin
            failures++;
            $display("FAIL idle_y got=%0d want=12", paddle_y);
        end
    endtask

    task automatic test_up_hold();
        wait_tile(6'd0, 6'd0);
        for (int k = 1; k <= 3; k++) move_q.push_back(exp_y - k);
        sw_up = 1'b1;
        repeat (6) wait_tile(6'd0, 6'd0);
        sw_up = 1'b0;
        wait_tile(6'd15, 6'd0);
        exp_y = exp_y - 3;
        checks++;
        if (paddle_y !== 5'(exp_y)) begin
            failures++;
            $display("FAIL up_hold_y got=%0d want=%0d", paddle_y, exp_y);
        end
        checks++;
        if (move_q.size() != 0) begin
            failures++;
            $display("FAIL up_hold_moves missing=%0d want=0", move_q.size());
        end
    endtask

    task automatic test_glitch();
        wait_tile(6'd0, 6'd0);
        sw_up = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sw_up = 1'b0;
        repeat (4) wait_tile(6'd0, 6'd0);
        checks++;
        if (paddle_y !== 5'(exp_y)) begin
            failures++;
            $display("FAIL glitch_y got=%0d want=%0d", paddle_y, exp_y);
        end
    endtask

    task automatic test_down_clamp();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst   = 1'b0;
        exp_y = 12;
        checks++;
        if (paddle_y !== 5'd12) begin
            failures++;
            $display("FAIL down_start_y got=%0d want=12", paddle_y);
        end
        wait_tile(6'd0, 6'd0);
        for (int k = 13; k <= 24; k++) move_q.push_back(k);
        sw_dn = 1'b1;
        repeat (40) wait_tile(6'd0, 6'd0);
        exp_y = 24;
        checks++;
        if (paddle_y !== 5'd24) begin
            failures++;
            $display("FAIL down_clamp_y got=%0d want=24", paddle_y);
        end
        run_draw_frame();
        sw_dn = 1'b0;
        checks++;
        if (move_q.size() != 0) begin
            failures++;
            $display("FAIL down_moves missing=%0d want=0", move_q.size());
        end
    endtask

    task automatic test_both();
        wait_tile(6'd0, 6'd0);
        sw_up = 1'b1;
        sw_dn = 1'b1;
        repeat (8) wait_tile(6'd0, 6'd0);
        checks++;
        if (paddle_y !== 5'(exp_y)) begin
            failures++;
            $display("FAIL both_y got=%0d want=%0d", paddle_y, exp_y);
        end
        sw_up = 1'b0;
        sw_dn = 1'b0;
        wait_tile(6'd0, 6'd0);
        checks++;
        if (paddle_y !== 5'(exp_y)) begin
            failures++;
            $display("FAIL both_after_y got=%0d want=%0d", paddle_y, exp_y);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 23; k >= 20; k--) move_q.push_back(k);
        wait_tile(6'd0, 6'd0);
        sw_up = 1'b1;
        for (int f = 0; f < 12; f++) begin
            wait_tile(6'd0, 6'd0);
            if (paddle_y == 5'd20) break;
        end
        sw_up = 1'b0;
        exp_y = 20;
        checks++;
        if (paddle_y !== 5'd20 || move_q.size() != 0) begin
            failures++;
            $display("FAIL reach20 got=%0d pending=%0d want=20 pending=0", paddle_y, move_q.size());
        end
        wait_tile(6'd10, 6'd3);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (paddle_y !== 5'd12 || draw !== 1'b0 || moving !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got y=%0d draw=%0b moving=%0b want y=12 draw=0 moving=0",
                     paddle_y, draw, moving);
        end
        exp_y = 12;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        sw_dn = 1'b1;
        move_q.push_back(13);
        wait_tile(6'd0, 6'd0);
        checks++;
        if (paddle_y !== 5'd12) begin
            failures++;
            $display("FAIL first_tick_after_reset got=%0d want=12", paddle_y);
        end
        wait_tile(6'd0, 6'd0);
        sw_dn = 1'b0;
        checks++;
        if (paddle_y !== 5'd13 || move_q.size() != 0) begin
            failures++;
            $display("FAIL resume_after_reset got=%0d pending=%0d want=13 pending=0",
                     paddle_y, move_q.size());
        end
    endtask

    initial begin
        rst   = 1'b1;
        sw_up = 1'b0;
        sw_dn = 1'b0;
        test_reset();
        test_up_hold();
        test_glitch();
        test_down_clamp();
        test_both();
        test_reset_mid();
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
